rv32i_alu: RTL and testbench
============================

# rv32i_alu

Registered 32-bit integer ALU for the RV32I core's execute stage. It computes the R-type and I-type arithmetic, logic and shift results, plus the branch-compare flags, from two operands: rs1 or PC, and rs2 or immediate. The result is captured in an output register with one-cycle latency.

## Interface
Parameters: none (datapath fixed at 32 bits, op at 4 bits).
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  32  operand A (rs1 or PC), two's complement
- b  input  32  operand B (rs2 or immediate), two's complement
- op  input  4  operation select (encoding below)
- y  output  32  registered result

## Operation
Opcode encoding (op value → registered y):
- 0 ADD: a + b, modulo 2^32
- 1 SUB: a − b, modulo 2^32
- 2 SLT: 1 if a < b (signed), else 0
- 3 SLTU: 1 if a < b (unsigned), else 0
- 4 XOR: a ^ b
- 5 OR: a | b
- 6 AND: a & b
- 7 SLL: a << b[4:0]
- 8 SRL: a >> b[4:0], logical, zero fill
- 9 SRA: a >>> b[4:0], sign fill
- 10 EQ: 1 if a == b
- 11 NEQ: 1 if a != b
- 12 GE: 1 if a >= b (signed)
- 13 GEU: 1 if a >= b (unsigned)
- 14, 15: y = 0

Rules:
- Compare results are zero-extended to 32 bits (0x00000001 or 0x00000000).
- Only b[4:0] is used as the shift amount; b[31:5] is ignored.
- Overflow and carry are discarded; there are no flag outputs.

## Timing
- y updates on every rising clk edge with f(a, b, op) sampled at that edge. Latency is 1 cycle and throughput is 1 result per cycle.
- There is no handshake and no enable; the register loads every cycle.
- Reset: when rst = 1 at a rising edge, y ← 0x00000000, and rst overrides any computation. On the first edge with rst = 0, y takes the ALU result.
- A reset asserted mid-stream drops the in-flight result. The next valid y appears one edge after rst deasserts.
- Inputs may change at any time between edges; only values at the edge matter.
- Combinational path (op decode → adder/shifter/compare → mux → register) must close in one cycle.

## Structure
- Shared package `rv32i_pkg`:
  - localparams for the 14 op codes (ALU_ADD … ALU_GEU)
  - localparam XLEN = 32
- One natural sub-module: `rv32i_alu_core`, a purely combinational function of (a, b, op) → result. The top adds only the reset-able output register.
- The core reuses a single subtractor for SUB, SLT, SLTU, GE and GEU.
- SRA is derived from sign-extended right shift.

## Test plan
Each case checks y one edge after the stimulus.
- Reset: hold rst = 1 with a = 1000, b = 500, op = 0 → y = 0. Release rst → next edge y = 1500.
- a = 1000, b = 500, sweep op 0–13:
  - 1500, 500, 0, 0
  - 540, 1020, 480
  - 1048576000 (SLL by 20), 0 (SRL), 0 (SRA)
  - 0, 1, 1, 1
- a = −1000, b = −500:
  - ADD −1500, SUB −500
  - SLT 1, SLTU 1
  - SRL 1048575 (0xFFFFFC18 >> 12), SRA −1
  - GE 0, GEU 0
- a = 1000, b = −1000: SUB 2000, SLT 0, SLTU 1, GE 1, GEU 0, NEQ 1.
- a = b = −1000 and a = b = 0:
  - EQ 1, NEQ 0, GE 1, GEU 1, SUB 0
  - XOR 0, AND a, OR a
- op = 14 and op = 15 with nonzero a, b → y = 0. Back-to-back op changes each cycle → each result appears exactly one edge later.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width and ALU operation codes.
package rv32i_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd2;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd5;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd6;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd7;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd8;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd9;
    localparam logic [OP_W-1:0] ALU_EQ   = 4'd10;
    localparam logic [OP_W-1:0] ALU_NEQ  = 4'd11;
    localparam logic [OP_W-1:0] ALU_GE   = 4'd12;
    localparam logic [OP_W-1:0] ALU_GEU  = 4'd13;

    // Zero-extend a single compare bit to a full result word.
    function automatic logic [XLEN-1:0] flag_word(input logic f);
        return {{(XLEN-1){1'b0}}, f};
    endfunction

endpackage

// File: rtl/rv32i_alu_core.sv
// Combinational RV32I ALU: one shared subtractor serves SUB and all ordered compares.
module rv32i_alu_core
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [OP_W-1:0] op,
    output logic [XLEN-1:0] result_c
);

    logic [XLEN:0]        w_diff;
    logic [XLEN-1:0]      w_sum;
    logic                 w_ltu;
    logic                 w_lt;
    logic                 w_eq;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [XLEN-1:0]      w_srl;
    logic [XLEN-1:0]      w_fill;
    logic [XLEN-1:0]      w_sra;

    assign w_sum = a + b;

    // a + ~b + 1: carry-out set means a >= b unsigned.
    assign w_diff = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
    assign w_ltu  = ~w_diff[XLEN];
    // Operands of differing sign decide by sign alone; otherwise the difference sign does.
    assign w_lt   = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : w_diff[XLEN-1];
    assign w_eq   = (a == b);

    assign w_shamt = b[SHAMT_W-1:0];
    assign w_srl   = a >> w_shamt;
    // Vacated high bits are refilled with copies of the sign bit.
    assign w_fill  = ~({XLEN{1'b1}} >> w_shamt);
    assign w_sra   = w_srl | (a[XLEN-1] ? w_fill : '0);

    always_comb begin
        result_c = '0;
        unique case (op)
            ALU_ADD:  result_c = w_sum;
            ALU_SUB:  result_c = w_diff[XLEN-1:0];
            ALU_SLT:  result_c = flag_word(w_lt);
            ALU_SLTU: result_c = flag_word(w_ltu);
            ALU_XOR:  result_c = a ^ b;
            ALU_OR:   result_c = a | b;
            ALU_AND:  result_c = a & b;
            ALU_SLL:  result_c = a << w_shamt;
            ALU_SRL:  result_c = w_srl;
            ALU_SRA:  result_c = w_sra;
            ALU_EQ:   result_c = flag_word(w_eq);
            ALU_NEQ:  result_c = flag_word(~w_eq);
            ALU_GE:   result_c = flag_word(~w_lt);
            ALU_GEU:  result_c = flag_word(~w_ltu);
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_alu.sv
// Registered RV32I execute-stage ALU: one-cycle latency, loads every cycle.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [OP_W-1:0] op,
    output logic [XLEN-1:0] y
);

    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] r_y;

    rv32i_alu_core u_core (
        .a        (a),
        .b        (b),
        .op       (op),
        .result_c (w_result)
    );

    always_ff @(posedge clk) begin
        if (rst) r_y <= '0;
        else     r_y <= w_result;
    end

    assign y = r_y;

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: directed test-plan vectors plus randomized ops vs. a reference model.
module tb_rv32i_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] y;

    int checks;
    int errors;

    rv32i_alu dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .op  (op),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model straight from the opcode table.
    function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [3:0] mop);
        int signed   sa;
        int signed   sb;
        int unsigned ua;
        int unsigned ub;
        int unsigned sh;
        sa = ma; sb = mb; ua = ma; ub = mb;
        sh = ub % 32;
        case (mop)
            4'd0:    return ma + mb;
            4'd1:    return ma - mb;
            4'd2:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:    return (ua < ub) ? 32'd1 : 32'd0;
            4'd4:    return ma ^ mb;
            4'd5:    return ma | mb;
            4'd6:    return ma & mb;
            4'd7:    return ma << sh;
            4'd8:    return ma >> sh;
            4'd9:    return 32'(sa >>> sh);
            4'd10:   return (ua == ub) ? 32'd1 : 32'd0;
            4'd11:   return (ua != ub) ? 32'd1 : 32'd0;
            4'd12:   return (sa >= sb) ? 32'd1 : 32'd0;
            4'd13:   return (ua >= ub) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one cycle of inputs, then check y just after the capturing edge.
    task automatic step(input logic srst, input logic [31:0] sa, input logic [31:0] sb,
                        input logic [3:0] sop, input logic [31:0] exp, input string tag);
        @(negedge clk);
        rst = srst; a = sa; b = sb; op = sop;
        @(posedge clk);
        #1;
        checks++;
        assert (y === exp) else begin
            errors++;
            $error("FAIL %s op=%0d a=%h b=%h observed=%h expected=%h", tag, sop, sa, sb, y, exp);
        end
    endtask

    logic [31:0] exp_pos [14] = '{32'd1500, 32'd500, 32'd0, 32'd0, 32'd540, 32'd1020, 32'd480,
                                  32'd1048576000, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
    logic [31:0] exp_neg [14] = '{32'hFFFFFA24, 32'hFFFFFE0C, 32'd1, 32'd1, 32'h00000214,
                                  32'hFFFFFE1C, 32'hFFFFFC08, 32'hFFC18000, 32'd1048575,
                                  32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 32'd0};
    logic [3:0]  mix_ops [6]  = '{4'd1, 4'd2, 4'd3, 4'd12, 4'd13, 4'd11};
    logic [31:0] mix_exp [6]  = '{32'd2000, 32'd0, 32'd1, 32'd1, 32'd0, 32'd1};
    logic [3:0]  eq_ops  [8]  = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd1, 4'd4, 4'd6, 4'd5};

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; a = '0; b = '0; op = '0;

        // Reset holds y at zero, release yields the sum one edge later.
        step(1'b1, 32'd1000, 32'd500, 4'd0, 32'd0, "reset_hold");
        step(1'b1, 32'd1000, 32'd500, 4'd0, 32'd0, "reset_hold2");
        step(1'b0, 32'd1000, 32'd500, 4'd0, 32'd1500, "reset_release");

        // Back-to-back op sweep on positive operands.
        for (int i = 0; i < 14; i++)
            step(1'b0, 32'd1000, 32'd500, 4'(i), exp_pos[i], "pos_sweep");

        // Negative operands (-1000, -500).
        for (int i = 0; i < 14; i++)
            step(1'b0, -32'sd1000, -32'sd500, 4'(i), exp_neg[i], "neg_sweep");

        // Mixed signs (1000, -1000).
        for (int i = 0; i < 6; i++)
            step(1'b0, 32'd1000, -32'sd1000, mix_ops[i], mix_exp[i], "mixed_sign");

        // Equal operands: -1000 and 0.
        for (int k = 0; k < 2; k++) begin
            logic [31:0] v;
            logic [31:0] e [8];
            v = (k == 0) ? 32'hFFFFFC18 : 32'd0;
            e = '{32'd1, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0, v, v};
            for (int i = 0; i < 8; i++)
                step(1'b0, v, v, eq_ops[i], e[i], "equal_ops");
        end

        // Unused op codes return zero.
        step(1'b0, 32'h1234_5678, 32'h0BAD_F00D, 4'd14, 32'd0, "op14");
        step(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd15, 32'd0, "op15");

        // Shift amount takes b[4:0] only.
        step(1'b0, 32'h8000_0001, 32'hFFFF_FFE4, 4'd9, 32'hF800_0000, "sra_upper_b");
        step(1'b0, 32'h8000_0001, 32'h0000_0020, 4'd8, 32'h8000_0001, "srl_shamt0");

        // Mid-stream reset drops the in-flight result.
        step(1'b0, 32'd7, 32'd8, 4'd0, 32'd15, "pre_reset");
        step(1'b1, 32'd7, 32'd8, 4'd0, 32'd0, "mid_reset");
        step(1'b0, 32'd7, 32'd8, 4'd1, 32'hFFFF_FFFF, "post_reset");

        // Randomized operands and ops, occasional reset.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [3:0]  rop;
            logic        rr;
            ra  = $urandom();
            rb  = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom());
            rop = 4'($urandom_range(0, 15));
            rr  = ($urandom_range(0, 15) == 0);
            step(rr, ra, rb, rop, rr ? 32'd0 : model(ra, rb, rop), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
